rr_arb4: RTL and testbench

Four-requester round-robin arbiter with burst locking that shares one downstream port (e.g. the single memory/bus port of the tinyrv1 datapath) between four valid/ready requesters. It owns the 2-bit select of the shared 4:1 message mux, holds a grant for the whole burst, and rotates priority after each burst. It sits between the requesting units (fetch, load/store, debug, DMA) and the shared resource.

---
 rtl/rr_arb4.sv | 101 ++++++++++
 tb/tb_rr_arb4.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with burst locking: owns the shared
// port's 4:1 message select, holds a grant until the owner's last beat.
module rr_arb4 #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_val,
  input  logic [3:0]       req_last,
  input  logic [nbits-1:0] req_msg0,
  input  logic [nbits-1:0] req_msg1,
  input  logic [nbits-1:0] req_msg2,
  input  logic [nbits-1:0] req_msg3,
  output logic [3:0]       req_rdy,
  output logic             out_val,
  output logic             out_last,
  output logic [nbits-1:0] out_msg,
  output logic [1:0]       out_id,
  input  logic             out_rdy,
  output logic [1:0]       sel,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic       hshk;

  // First set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); lower offsets
  // are visited last so they win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Payload mux follows the registered owner in every state.
  always_comb begin
    out_msg = req_msg0;
    case (owner)
      2'd0:    out_msg = req_msg0;
      2'd1:    out_msg = req_msg1;
      2'd2:    out_msg = req_msg2;
      default: out_msg = req_msg3;
    endcase
  end

  assign sel      = owner;
  assign out_id   = owner;
  assign out_last = req_last[owner];
  assign hshk     = out_val & out_rdy;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    out_val   = 1'b0;
    req_rdy   = 4'b0000;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_val) begin
          owner_nxt = rr_pick(req_val, ptr);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        busy           = 1'b1;
        out_val        = req_val[owner];
        req_rdy[owner] = out_rdy;
        // A stalled owner keeps the grant; only its last beat releases it.
        if (hshk && out_last) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: reset, single request, rotation, burst lock,
// backpressure and owner stall, checked with immediate assertions.
module tb_rr_arb4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_val;
  logic [3:0]  req_last;
  logic [31:0] req_msg0, req_msg1, req_msg2, req_msg3;
  logic [3:0]  req_rdy;
  logic        out_val;
  logic        out_last;
  logic [31:0] out_msg;
  logic [1:0]  out_id;
  logic        out_rdy;
  logic [1:0]  sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  rr_arb4 #(.nbits(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_last(req_last),
    .req_msg0(req_msg0), .req_msg1(req_msg1), .req_msg2(req_msg2), .req_msg3(req_msg3),
    .req_rdy(req_rdy), .out_val(out_val), .out_last(out_last), .out_msg(out_msg),
    .out_id(out_id), .out_rdy(out_rdy), .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] id, input logic [3:0] rdy);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " out_id"}, 32'(out_id), 32'(id));
    chk({tag, " sel"}, 32'(sel), 32'(id));
    chk({tag, " req_rdy"}, 32'(req_rdy), 32'(rdy));
  endtask

  initial begin
    logic [1:0] rr_order [5];
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; req_val = 4'b0; req_last = 4'b0; out_rdy = 1'b0;
    req_msg0 = 32'hA0; req_msg1 = 32'hA1; req_msg2 = 32'hA2; req_msg3 = 32'hA3;
    cyc(); cyc();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_val", 32'(out_val), 32'd0);
    chk("rst req_rdy", 32'(req_rdy), 32'd0);
    chk("rst sel", 32'(sel), 32'd0);
    rst_n = 1'b1;

    // Single request from requester 2
    cyc();
    req_val = 4'b0100; req_last = 4'b0100; req_msg2 = 32'hDEADBEEF; out_rdy = 1'b1;
    #1;
    chk("single idle out_val", 32'(out_val), 32'd0);
    cyc();
    chk("single out_val", 32'(out_val), 32'd1);
    chk("single out_msg", out_msg, 32'hDEADBEEF);
    chk_grant("single", 2'd2, 4'b0100);
    cyc();
    req_val = 4'b1001; req_last = 4'b1111;
    #1;
    chk("single released", 32'(busy), 32'd0);

    // ptr=3 after requester 2: between 0 and 3, requester 3 wins
    cyc();
    chk_grant("ptr3 pick", 2'd3, 4'b1000);
    cyc();
    req_val = 4'b1111;
    #1;
    chk("rr start idle", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_grant($sformatf("rr%0d", k), rr_order[k], 4'b0001 << rr_order[k]);
      cyc();
      chk($sformatf("rr%0d bubble", k), 32'(busy), 32'd0);
    end
    req_val = 4'b0000;
    cyc();

    // Burst lock: requester 1 (ptr=1) sends three beats with 0 and 3 pending
    req_val = 4'b1011; req_last = 4'b1001; req_msg1 = 32'h11;
    req_msg0 = 32'hA0; req_msg3 = 32'hA3;
    cyc();
    chk("burst b1 msg", out_msg, 32'h11);
    chk("burst b1 last", 32'(out_last), 32'd0);
    chk_grant("burst b1", 2'd1, 4'b0010);
    cyc();
    req_msg1 = 32'h12;
    #1;
    chk("burst b2 msg", out_msg, 32'h12);
    chk("burst b2 id", 32'(out_id), 32'd1);
    cyc();
    req_msg1 = 32'h13; req_last = 4'b1011;
    #1;
    chk("burst b3 msg", out_msg, 32'h13);
    chk("burst b3 last", 32'(out_last), 32'd1);
    chk("burst b3 id", 32'(out_id), 32'd1);
    cyc();
    req_val = 4'b1001;
    #1;
    chk("burst bubble", 32'(busy), 32'd0);
    cyc();
    chk_grant("burst next3", 2'd3, 4'b1000);
    chk("burst next3 msg", out_msg, 32'hA3);
    cyc();
    req_val = 4'b0001;
    cyc();
    chk_grant("burst next0", 2'd0, 4'b0001);
    chk("burst next0 msg", out_msg, 32'hA0);
    cyc();
    req_val = 4'b0000;
    cyc();

    // Backpressure on owner 0 (ptr=1, only requester 0 asks)
    req_val = 4'b0001; req_last = 4'b0001; req_msg0 = 32'h55; out_rdy = 1'b0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d out_val", k), 32'(out_val), 32'd1);
      chk($sformatf("bp%0d msg", k), out_msg, 32'h55);
      chk_grant($sformatf("bp%0d", k), 2'd0, 4'b0000);
      cyc();
    end
    out_rdy = 1'b1;
    #1;
    chk("bp release rdy", 32'(req_rdy), 32'b0001);
    cyc();
    req_val = 4'b0000;
    #1;
    chk("bp single hshk", 32'(busy), 32'd0);
    cyc();

    // Owner stall: requester 1 drops val mid-burst while 2 waits (ptr=1)
    req_val = 4'b0010; req_last = 4'b0000; req_msg1 = 32'h21;
    cyc();
    chk_grant("stall b1", 2'd1, 4'b0010);
    chk("stall b1 val", 32'(out_val), 32'd1);
    cyc();
    req_val = 4'b0100; req_last = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d out_val", k), 32'(out_val), 32'd0);
      chk_grant($sformatf("stall%0d", k), 2'd1, 4'b0010);
      cyc();
    end
    req_val = 4'b0110; req_last = 4'b0110; req_msg1 = 32'h22;
    #1;
    chk("stall last val", 32'(out_val), 32'd1);
    chk("stall last last", 32'(out_last), 32'd1);
    chk("stall last msg", out_msg, 32'h22);
    cyc();
    req_val = 4'b0100;
    #1;
    chk("stall bubble", 32'(busy), 32'd0);
    cyc();
    out_rdy = 1'b0;
    #1;
    chk_grant("stall next2", 2'd2, 4'b0000);
    cyc();

    // Asynchronous reset mid-GRANT with owner 2
    chk("pre-rst sel", 32'(sel), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst out_val", 32'(out_val), 32'd0);
    chk("midrst req_rdy", 32'(req_rdy), 32'd0);
    chk("midrst sel", 32'(sel), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out_msg", out_msg, req_msg0);
    cyc();
    rst_n = 1'b1; req_val = 4'b0000; out_rdy = 1'b1;
    cyc(); cyc();
    chk("postrst idle", 32'(busy), 32'd0);
    // ptr back to 0: between 1 and 3, requester 1 wins
    req_val = 4'b1010; req_last = 4'b1010;
    cyc();
    chk_grant("postrst pick", 2'd1, 4'b0010);
    cyc();
    req_val = 4'b0000;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
